// File: rtl/snes_snooper_mp_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// snes_snooper_mp_if : SNES joypad bus (shared latch/clock, one data line per port)
// Rev 1.0
// ---------------------------------------------------------------------------
interface snes_snooper_mp_if #(
  parameter int NUM_PORTS = 2
);
  logic                 snes_clk;
  logic                 snes_latch;
  logic [NUM_PORTS-1:0] snes_data;

  modport master (output snes_clk, output snes_latch, output snes_data);
  modport slave  (input  snes_clk, input  snes_latch, input  snes_data);
endinterface
`default_nettype wire

// File: rtl/snes_snooper_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// snes_snooper_mp : passive multi-port SNES joypad snooper (sync, deglitch, deserialise)
// Rev 1.0
// ---------------------------------------------------------------------------
module snes_snooper_mp #(
  parameter int NUM_PORTS  = 2,
  parameter int BITS       = 16,
  parameter int FILTER_LEN = 3,
  parameter int TIMEOUT    = 4096,
  parameter int INVERT     = 1,
  parameter int CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  snes_snooper_mp_if.slave          bus,
  output logic [NUM_PORTS*BITS-1:0] state,
  output logic                      valid,
  output logic [NUM_PORTS-1:0]      changed,
  output logic [CNT_W-1:0]          frame_cnt,
  output logic                      err,
  output logic                      busy
);

  localparam int NS = NUM_PORTS + 2;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic INV = (INVERT != 0);
  // Bit order {data, clk, latch}; bus idles with data high, clock high, latch low
  localparam logic [NS-1:0] IDLE_LVL = {{NUM_PORTS{1'b1}}, 1'b1, 1'b0};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LATCH = 2'd1, S_SHIFT = 2'd2} fsm_t;

  logic [NS-1:0] raw, sync1, sync2, filt, filt_q;
  logic          latch_rise, latch_fall, clk_fall;
  logic [NUM_PORTS-1:0] data_f;

  fsm_t                      fsm, fsm_n;
  logic [IW-1:0]             bit_idx, bit_idx_n;
  logic [TW-1:0]             timer, timer_n;
  logic [NUM_PORTS*BITS-1:0] shift, shift_n;
  logic [NUM_PORTS-1:0]      changed_n;
  logic                      commit, abort;

  assign raw = {bus.snes_data, bus.snes_clk, bus.snes_latch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= IDLE_LVL;
      sync2  <= IDLE_LVL;
      filt_q <= IDLE_LVL;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      filt_q <= filt;
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_filt
    logic [FW-1:0] cnt;
    logic          f;
    // cnt tracks consecutive samples that disagree with the current output
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        f   <= IDLE_LVL[s];
      end else if (sync2[s] == f) begin
        cnt <= '0;
      end else if (cnt == FW'(FILTER_LEN - 1)) begin
        cnt <= '0;
        f   <= sync2[s];
      end else begin
        cnt <= cnt + FW'(1);
      end
    end
    assign filt[s] = f;
  end

  assign latch_rise = filt[0] & ~filt_q[0];
  assign latch_fall = ~filt[0] & filt_q[0];
  assign clk_fall   = ~filt[1] & filt_q[1];
  assign data_f     = filt[NS-1:2];
  assign busy       = (fsm != S_IDLE);

  always_comb begin
    fsm_n     = fsm;
    bit_idx_n = bit_idx;
    timer_n   = timer;
    shift_n   = shift;
    changed_n = changed;
    commit    = 1'b0;
    abort     = 1'b0;
    if (fsm != S_IDLE && timer != TW'(TIMEOUT)) timer_n = timer + TW'(1);
    case (fsm)
      S_IDLE: begin
        if (latch_rise) begin
          fsm_n   = S_LATCH;
          timer_n = '0;
        end
      end
      S_LATCH: begin
        if (timer == TW'(TIMEOUT)) begin
          abort = 1'b1;
          fsm_n = S_IDLE;
        end else if (latch_fall) begin
          fsm_n     = S_SHIFT;
          bit_idx_n = '0;
          timer_n   = '0;
        end
      end
      S_SHIFT: begin
        // A new latch takes priority over a coincident clock edge
        if (latch_rise) begin
          abort   = 1'b1;
          fsm_n   = S_LATCH;
          timer_n = '0;
        end else if (timer == TW'(TIMEOUT)) begin
          abort = 1'b1;
          fsm_n = S_IDLE;
        end else if (clk_fall) begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            for (int i = 0; i < BITS; i++) begin
              if (bit_idx == IW'(i)) shift_n[p*BITS + i] = data_f[p] ^ INV;
            end
          end
          timer_n = '0;
          if (bit_idx == IW'(BITS - 1)) begin
            commit    = 1'b1;
            fsm_n     = S_IDLE;
            bit_idx_n = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
              changed_n[p] = (shift_n[p*BITS +: BITS] != state[p*BITS +: BITS]);
            end
          end else begin
            bit_idx_n = bit_idx + IW'(1);
          end
        end
      end
      default: fsm_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      bit_idx   <= '0;
      timer     <= '0;
      shift     <= '0;
      state     <= '0;
      valid     <= 1'b0;
      changed   <= '0;
      frame_cnt <= '0;
      err       <= 1'b0;
    end else begin
      fsm     <= fsm_n;
      bit_idx <= bit_idx_n;
      timer   <= timer_n;
      shift   <= shift_n;
      valid   <= commit;
      err     <= abort;
      changed <= changed_n;
      if (commit) begin
        state     <= shift_n;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snes_snooper_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_snes_snooper_mp : directed self-checking bench (16-bit and 32-bit instances)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_snes_snooper_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       drv_clk, drv_latch, sel;
  logic [1:0] drv_data;
  int         cyc = 0;

  snes_snooper_mp_if #(.NUM_PORTS(2)) bus_a ();
  snes_snooper_mp_if #(.NUM_PORTS(2)) bus_b ();

  // sel routes the driven bus to instance b; the other sees an idle bus
  assign bus_a.snes_clk   = sel ? 1'b1  : drv_clk;
  assign bus_a.snes_latch = sel ? 1'b0  : drv_latch;
  assign bus_a.snes_data  = sel ? 2'b11 : drv_data;
  assign bus_b.snes_clk   = sel ? drv_clk   : 1'b1;
  assign bus_b.snes_latch = sel ? drv_latch : 1'b0;
  assign bus_b.snes_data  = sel ? drv_data  : 2'b11;

  logic [31:0] state_a;
  logic        valid_a, err_a, busy_a;
  logic [1:0]  changed_a;
  logic [7:0]  cnt_a;
  logic [63:0] state_b;
  logic        valid_b, err_b, busy_b;
  logic [1:0]  changed_b;
  logic [1:0]  cnt_b;

  snes_snooper_mp #(
    .NUM_PORTS(2), .BITS(16), .FILTER_LEN(3), .TIMEOUT(64), .INVERT(1), .CNT_W(8)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .state(state_a), .valid(valid_a), .changed(changed_a),
    .frame_cnt(cnt_a), .err(err_a), .busy(busy_a)
  );

  snes_snooper_mp #(
    .NUM_PORTS(2), .BITS(32), .FILTER_LEN(3), .TIMEOUT(64), .INVERT(1), .CNT_W(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .state(state_b), .valid(valid_b), .changed(changed_b),
    .frame_cnt(cnt_b), .err(err_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int nv_a = 0, ne_a = 0, nv_b = 0, ne_b = 0;
  int err_cyc_a = 0;
  int last_fall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a) nv_a++;
    if (err_a) begin
      ne_a++;
      err_cyc_a = cyc;
    end
    if (valid_b) nv_b++;
    if (err_b) ne_b++;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // w0/w1 are pressed-button words (1 = pressed); the line carries the inverse
  task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1,
                            input int nbits, input bit do_latch, input bit glitch);
    if (do_latch) begin
      drv_latch = 1'b1;
      wait_clks(6);
      drv_latch = 1'b0;
      wait_clks(6);
    end
    for (int i = 0; i < nbits; i++) begin
      drv_data = {~w1[i], ~w0[i]};
      wait_clks(3);
      if (glitch && i == 5) begin
        drv_clk = 1'b0; wait_clks(1);
        drv_clk = 1'b1; wait_clks(3);
        drv_clk = 1'b0; wait_clks(2);
        drv_clk = 1'b1; wait_clks(3);
      end
      wait_clks(3);
      drv_clk   = 1'b0;
      last_fall = cyc;
      wait_clks(6);
      drv_clk = 1'b1;
    end
    drv_data = 2'b11;
  endtask

  int v0, e0, lat;

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    drv_clk = 1'b1; drv_latch = 1'b0; drv_data = 2'b11;
    wait_clks(4);
    check_val("rst_state",   {32'b0, state_a}, 64'h0);
    check_val("rst_valid",   {63'b0, valid_a}, 64'h0);
    check_val("rst_changed", {62'b0, changed_a}, 64'h0);
    check_val("rst_cnt",     {56'b0, cnt_a}, 64'h0);
    check_val("rst_err",     {63'b0, err_a}, 64'h0);
    check_val("rst_busy",    {63'b0, busy_a}, 64'h0);
    rst_n = 1'b1;
    wait_clks(4);

    // Standard frame: port0 pressed on bits 0 and 3, port1 nothing
    v0 = nv_a; e0 = ne_a;
    send_frame(32'h0009, 32'h0, 16, 1'b1, 1'b0);
    wait_clks(20);
    check_val("f1_state",   {32'b0, state_a}, 64'h0000_0009);
    check_val("f1_valid",   64'(nv_a - v0), 64'd1);
    check_val("f1_changed", {62'b0, changed_a}, 64'b01);
    check_val("f1_cnt",     {56'b0, cnt_a}, 64'd1);
    check_val("f1_err",     64'(ne_a - e0), 64'd0);

    v0 = nv_a;
    send_frame(32'h0009, 32'h0, 16, 1'b1, 1'b0);
    wait_clks(20);
    check_val("f2_state",   {32'b0, state_a}, 64'h0000_0009);
    check_val("f2_valid",   64'(nv_a - v0), 64'd1);
    check_val("f2_changed", {62'b0, changed_a}, 64'b00);
    check_val("f2_cnt",     {56'b0, cnt_a}, 64'd2);

    // 1- and 2-cycle clock spikes must not be taken as bits
    send_frame(32'hA5C3, 32'h1234, 16, 1'b1, 1'b1);
    wait_clks(20);
    check_val("gl_state",   {32'b0, state_a}, 64'h1234_A5C3);
    check_val("gl_changed", {62'b0, changed_a}, 64'b11);
    check_val("gl_cnt",     {56'b0, cnt_a}, 64'd3);

    // Latch after 7 bits restarts the frame
    v0 = nv_a; e0 = ne_a;
    send_frame(32'h00FF, 32'h00FF, 7, 1'b1, 1'b0);
    send_frame(32'h8001, 32'hFFFF, 16, 1'b1, 1'b0);
    wait_clks(20);
    check_val("rl_err",     64'(ne_a - e0), 64'd1);
    check_val("rl_valid",   64'(nv_a - v0), 64'd1);
    check_val("rl_state",   {32'b0, state_a}, 64'hFFFF_8001);
    check_val("rl_cnt",     {56'b0, cnt_a}, 64'd4);
    check_val("rl_changed", {62'b0, changed_a}, 64'b11);

    // Five bits then silence: frame times out
    v0 = nv_a; e0 = ne_a;
    send_frame(32'h001F, 32'h0, 5, 1'b1, 1'b0);
    check_val("to_busy_mid", {63'b0, busy_a}, 64'd1);
    wait_clks(100);
    lat = err_cyc_a - last_fall;
    check_val("to_err",     64'(ne_a - e0), 64'd1);
    check_val("to_latency", {63'b0, (lat >= 64 && lat <= 72)}, 64'd1);
    check_val("to_busy",    {63'b0, busy_a}, 64'd0);
    check_val("to_state",   {32'b0, state_a}, 64'hFFFF_8001);
    check_val("to_cnt",     {56'b0, cnt_a}, 64'd4);
    check_val("to_valid",   64'(nv_a - v0), 64'd0);

    // 32-bit instance: full capture, trailing pulses ignored, counter wrap
    sel = 1'b1;
    wait_clks(10);
    send_frame(32'hDEAD_BEEF, 32'h0000_0001, 32, 1'b1, 1'b0);
    send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 1'b0, 1'b0);
    wait_clks(20);
    check_val("ex_state",   state_b, 64'h0000_0001_DEAD_BEEF);
    check_val("ex_valid",   64'(nv_b), 64'd1);
    check_val("ex_changed", {62'b0, changed_b}, 64'b11);
    check_val("ex_cnt",     {62'b0, cnt_b}, 64'd1);
    check_val("ex_busy",    {63'b0, busy_b}, 64'd0);
    for (int k = 2; k <= 5; k++) begin
      send_frame(32'(k), 32'h1, 32, 1'b1, 1'b0);
      wait_clks(20);
    end
    check_val("wr_cnt",     {62'b0, cnt_b}, 64'd1);
    check_val("wr_state",   state_b, 64'h0000_0001_0000_0005);
    check_val("wr_changed", {62'b0, changed_b}, 64'b01);
    check_val("wr_valid",   64'(nv_b), 64'd5);

    // Reset mid-frame clears outputs without waiting for a clock edge
    send_frame(32'h0000_00AA, 32'h0, 10, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_val("mr_state_b", state_b, 64'h0);
    check_val("mr_cnt_b",   {62'b0, cnt_b}, 64'd0);
    check_val("mr_busy_b",  {63'b0, busy_b}, 64'd0);
    check_val("mr_chg_b",   {62'b0, changed_b}, 64'd0);
    check_val("mr_valid_b", {63'b0, valid_b}, 64'd0);
    check_val("mr_err_b",   {63'b0, err_b}, 64'd0);
    check_val("mr_state_a", {32'b0, state_a}, 64'h0);
    check_val("mr_cnt_a",   {56'b0, cnt_a}, 64'd0);
    drv_clk = 1'b1; drv_latch = 1'b0; drv_data = 2'b11;
    wait_clks(4);
    rst_n = 1'b1;
    sel   = 1'b0;
    wait_clks(10);
    send_frame(32'h0009, 32'h0, 16, 1'b1, 1'b0);
    wait_clks(20);
    check_val("rc_state", {32'b0, state_a}, 64'h0000_0009);
    check_val("rc_cnt",   {56'b0, cnt_a}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
